// File: rtl/hierarchical_fifo_system_if.sv
// Handshake and status bundle for hierarchical_fifo_system.
// The producer/consumer side uses the master modport; the FIFO uses slave.
interface hierarchical_fifo_system_if #(
  parameter int DATA_WIDTH = 16
);
  logic [1:0]            fifo_mode;
  logic [7:0]            watermark_l1;
  logic [7:0]            watermark_l2;
  logic [7:0]            watermark_l3;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  wr_full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_empty;
  logic [1:0]            wr_level;
  logic [1:0]            rd_level;
  logic [31:0]           fifo_status;
  logic [2:0]            level_overflow;
  logic                  backpressure_active;

  modport master (
    output fifo_mode, watermark_l1, watermark_l2, watermark_l3,
    output wr_data, wr_en, rd_en,
    input  wr_full, rd_data, rd_empty, wr_level, rd_level,
    input  fifo_status, level_overflow, backpressure_active
  );

  modport slave (
    input  fifo_mode, watermark_l1, watermark_l2, watermark_l3,
    input  wr_data, wr_en, rd_en,
    output wr_full, rd_data, rd_empty, wr_level, rd_level,
    output fifo_status, level_overflow, backpressure_active
  );
endinterface

// File: rtl/hierarchical_fifo_system.sv
// Three-level order-preserving FIFO. L1 holds the oldest words, L2 the
// next, L3 the newest. Writes land in the shallowest level that keeps the
// ordering intact; each cycle one word may hop L2->L1 and one L3->L2, so a
// consumer reading from the L1 head never stalls while data exists anywhere.
// Depths are expected to be powers of two so pointers wrap naturally.
module hierarchical_fifo_system #(
  parameter int DATA_WIDTH = 16,
  parameter int L1_DEPTH   = 32,
  parameter int L2_DEPTH   = 128,
  parameter int L3_DEPTH   = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  hierarchical_fifo_system_if.slave bus
);

  localparam int L1_AW = $clog2(L1_DEPTH);
  localparam int L2_AW = $clog2(L2_DEPTH);
  localparam int L3_AW = $clog2(L3_DEPTH);
  localparam int L1_CW = L1_AW + 1;
  localparam int L2_CW = L2_AW + 1;
  localparam int L3_CW = L3_AW + 1;
  // Product width for watermark compares: 512*100 needs 16 bits, keep headroom.
  localparam int PW    = 18;

  localparam logic [L1_CW-1:0] L1_FULL_CNT = L1_CW'(L1_DEPTH);
  localparam logic [L2_CW-1:0] L2_FULL_CNT = L2_CW'(L2_DEPTH);
  localparam logic [L3_CW-1:0] L3_FULL_CNT = L3_CW'(L3_DEPTH);

  // ---------------------------------------------------------------------
  // Storage and per-level state
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_l1_mem [L1_DEPTH];
  logic [DATA_WIDTH-1:0] r_l2_mem [L2_DEPTH];
  logic [DATA_WIDTH-1:0] r_l3_mem [L3_DEPTH];

  logic [L1_AW-1:0] r_l1_head;
  logic [L1_AW-1:0] r_l1_tail;
  logic [L2_AW-1:0] r_l2_head;
  logic [L2_AW-1:0] r_l2_tail;
  logic [L3_AW-1:0] r_l3_head;
  logic [L3_AW-1:0] r_l3_tail;

  // Occupancy counters; names kept plain because they are probed externally.
  logic [L1_CW-1:0] l1_count;
  logic [L2_CW-1:0] l2_count;
  logic [L3_CW-1:0] l3_count;

  // ---------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------
  logic             w_l1_empty;
  logic             w_l2_empty;
  logic             w_l3_empty;
  logic             w_l1_full;
  logic             w_l2_full;
  logic             w_l3_full;
  logic [1:0]       w_max_level;
  logic [1:0]       w_wr_target;
  logic             w_target_full;
  logic             w_wr_full;
  logic             w_wr_accept;
  logic             w_pop;
  logic [L1_CW-1:0] w_l1_after_pop;
  logic [L2_CW-1:0] w_l2_after_ref;
  logic             w_ref21;
  logic             w_ref32;
  logic             w_l1_push;
  logic             w_l2_push;
  logic             w_l3_push;
  logic [1:0]       w_rd_level;

  logic [DATA_WIDTH-1:0] w_l1_head_data;
  logic [DATA_WIDTH-1:0] w_l2_head_data;
  logic [DATA_WIDTH-1:0] w_l3_head_data;
  logic [DATA_WIDTH-1:0] w_l1_push_data;
  logic [DATA_WIDTH-1:0] w_l2_push_data;

  logic [7:0]    w_wm1;
  logic [7:0]    w_wm2;
  logic [7:0]    w_wm3;
  logic [PW-1:0] w_l1_fill;
  logic [PW-1:0] w_l2_fill;
  logic [PW-1:0] w_l3_fill;
  logic [PW-1:0] w_l1_mark;
  logic [PW-1:0] w_l2_mark;
  logic [PW-1:0] w_l3_mark;
  logic [2:0]    w_level_overflow;
  logic          w_backpressure;

  assign w_l1_empty = (l1_count == L1_CW'(0));
  assign w_l2_empty = (l2_count == L2_CW'(0));
  assign w_l3_empty = (l3_count == L3_CW'(0));
  assign w_l1_full  = (l1_count == L1_FULL_CNT);
  assign w_l2_full  = (l2_count == L2_FULL_CNT);
  assign w_l3_full  = (l3_count == L3_FULL_CNT);

  assign w_l1_head_data = r_l1_mem[r_l1_head];
  assign w_l2_head_data = r_l2_mem[r_l2_head];
  assign w_l3_head_data = r_l3_mem[r_l3_head];

  // Deepest level the current mode lets new writes use.
  always_comb begin
    w_max_level = 2'd2;
    case (bus.fifo_mode)
      2'b00:   w_max_level = 2'd0;
      2'b01:   w_max_level = 2'd1;
      default: w_max_level = 2'd2;
    endcase
  end

  // A write must go behind the newest resident word, so it targets the
  // deepest non-empty level, or the next level down once a level is full.
  always_comb begin
    w_wr_target = 2'd0;
    if (!w_l3_empty || w_l2_full) begin
      w_wr_target = 2'd2;
    end else if (!w_l2_empty || w_l1_full) begin
      w_wr_target = 2'd1;
    end else begin
      w_wr_target = 2'd0;
    end
  end

  // Fullness of the level the next write would land in.
  always_comb begin
    w_target_full = 1'b0;
    case (w_wr_target)
      2'd0:    w_target_full = w_l1_full;
      2'd1:    w_target_full = w_l2_full;
      2'd2:    w_target_full = w_l3_full;
      default: w_target_full = 1'b1;
    endcase
  end

  // Full when the target is disabled by the mode or has no room.
  assign w_wr_full   = (w_wr_target > w_max_level) || w_target_full;
  assign w_wr_accept = bus.wr_en && !w_wr_full;
  assign w_pop       = bus.rd_en && !w_l1_empty;

  // Refills look at the space left after this cycle's outgoing word so that
  // a level that is full but being drained can still accept a hop.
  assign w_l1_after_pop = l1_count - L1_CW'(w_pop);
  assign w_ref21        = !w_l2_empty && (w_l1_after_pop < L1_FULL_CNT);
  assign w_l2_after_ref = l2_count - L2_CW'(w_ref21);
  assign w_ref32        = !w_l3_empty && (w_l2_after_ref < L2_FULL_CNT);

  // A write into L1 implies L2 is empty, so it never collides with a refill;
  // likewise a write into L2 implies L3 is empty.
  assign w_l1_push = (w_wr_accept && (w_wr_target == 2'd0)) || w_ref21;
  assign w_l2_push = (w_wr_accept && (w_wr_target == 2'd1)) || w_ref32;
  assign w_l3_push =  w_wr_accept && (w_wr_target == 2'd2);

  assign w_l1_push_data = w_ref21 ? w_l2_head_data : bus.wr_data;
  assign w_l2_push_data = w_ref32 ? w_l3_head_data : bus.wr_data;

  // Highest-index level that currently holds data.
  always_comb begin
    w_rd_level = 2'd0;
    if (!w_l3_empty) begin
      w_rd_level = 2'd2;
    end else if (!w_l2_empty) begin
      w_rd_level = 2'd1;
    end else begin
      w_rd_level = 2'd0;
    end
  end

  // ---------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------

  // L1 pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_l1_head <= L1_AW'(0);
      r_l1_tail <= L1_AW'(0);
      l1_count  <= L1_CW'(0);
    end else begin
      if (w_l1_push) r_l1_tail <= r_l1_tail + L1_AW'(1);
      if (w_pop)     r_l1_head <= r_l1_head + L1_AW'(1);
      l1_count <= l1_count + L1_CW'(w_l1_push) - L1_CW'(w_pop);
    end
  end

  // L2 pointers and occupancy; its pop is the hop into L1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_l2_head <= L2_AW'(0);
      r_l2_tail <= L2_AW'(0);
      l2_count  <= L2_CW'(0);
    end else begin
      if (w_l2_push) r_l2_tail <= r_l2_tail + L2_AW'(1);
      if (w_ref21)   r_l2_head <= r_l2_head + L2_AW'(1);
      l2_count <= l2_count + L2_CW'(w_l2_push) - L2_CW'(w_ref21);
    end
  end

  // L3 pointers and occupancy; its pop is the hop into L2.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_l3_head <= L3_AW'(0);
      r_l3_tail <= L3_AW'(0);
      l3_count  <= L3_CW'(0);
    end else begin
      if (w_l3_push) r_l3_tail <= r_l3_tail + L3_AW'(1);
      if (w_ref32)   r_l3_head <= r_l3_head + L3_AW'(1);
      l3_count <= l3_count + L3_CW'(w_l3_push) - L3_CW'(w_ref32);
    end
  end

  // Data arrays; contents are not cleared by reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (w_l1_push) r_l1_mem[r_l1_tail] <= w_l1_push_data;
    if (w_l2_push) r_l2_mem[r_l2_tail] <= w_l2_push_data;
    if (w_l3_push) r_l3_mem[r_l3_tail] <= bus.wr_data;
  end

  // ---------------------------------------------------------------------
  // Watermarks and status
  // ---------------------------------------------------------------------
  assign w_wm1 = (bus.watermark_l1 > 8'd100) ? 8'd100 : bus.watermark_l1;
  assign w_wm2 = (bus.watermark_l2 > 8'd100) ? 8'd100 : bus.watermark_l2;
  assign w_wm3 = (bus.watermark_l3 > 8'd100) ? 8'd100 : bus.watermark_l3;

  // count*100 >= percent*depth avoids a divider.
  assign w_l1_fill = PW'(l1_count) * PW'(100);
  assign w_l2_fill = PW'(l2_count) * PW'(100);
  assign w_l3_fill = PW'(l3_count) * PW'(100);
  assign w_l1_mark = PW'(w_wm1) * PW'(L1_DEPTH);
  assign w_l2_mark = PW'(w_wm2) * PW'(L2_DEPTH);
  assign w_l3_mark = PW'(w_wm3) * PW'(L3_DEPTH);

  assign w_level_overflow[0] = !w_l1_empty && (w_l1_fill >= w_l1_mark);
  assign w_level_overflow[1] = !w_l2_empty && (w_l2_fill >= w_l2_mark);
  assign w_level_overflow[2] = !w_l3_empty && (w_l3_fill >= w_l3_mark);

  // Backpressure follows the deepest level new writes can still reach.
  always_comb begin
    w_backpressure = w_wr_full;
    case (w_max_level)
      2'd0:    w_backpressure = w_level_overflow[0] || w_wr_full;
      2'd1:    w_backpressure = w_level_overflow[1] || w_wr_full;
      default: w_backpressure = w_level_overflow[2] || w_wr_full;
    endcase
  end

  assign bus.wr_full             = w_wr_full;
  assign bus.rd_empty            = w_l1_empty;
  assign bus.rd_data             = w_l1_empty ? DATA_WIDTH'(0) : w_l1_head_data;
  assign bus.wr_level            = w_wr_target;
  assign bus.rd_level            = w_rd_level;
  assign bus.level_overflow      = w_level_overflow;
  assign bus.backpressure_active = w_backpressure;
  assign bus.fifo_status         = {bus.fifo_mode, w_wr_full, w_l1_empty,
                                    w_backpressure, w_level_overflow,
                                    l3_count, l2_count, l1_count};

endmodule

// File: tb/tb_hierarchical_fifo_system.sv
// Self-checking bench for hierarchical_fifo_system: three model queues
// advanced by the level rules, compared against the DUT every cycle, plus
// directed scenarios with hand-computed data sequences and counts.
module tb_hierarchical_fifo_system;

  logic clk;
  logic rst;

  hierarchical_fifo_system_if bus_if ();

  hierarchical_fifo_system dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit model_live = 1'b0;

  logic [15:0] q1[$];
  logic [15:0] q2[$];
  logic [15:0] q3[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: actual=%0h expected=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int m_maxl();
    return (bus_if.fifo_mode == 2'b00) ? 0 : (bus_if.fifo_mode == 2'b01) ? 1 : 2;
  endfunction

  function automatic int m_target();
    if (q3.size() > 0 || q2.size() == 128) return 2;
    if (q2.size() > 0 || q1.size() == 32) return 1;
    return 0;
  endfunction

  function automatic bit m_full();
    int t = m_target();
    if (t > m_maxl()) return 1'b1;
    return (t == 2) && (q3.size() == 512);
  endfunction

  function automatic int m_rdlevel();
    if (q3.size() > 0) return 2;
    if (q2.size() > 0) return 1;
    return 0;
  endfunction

  function automatic int clamp100(input logic [7:0] w);
    return (int'(w) > 100) ? 100 : int'(w);
  endfunction

  function automatic logic [2:0] m_overflow();
    logic [2:0] lo;
    lo[0] = (q1.size() != 0) && (q1.size() * 100 >= clamp100(bus_if.watermark_l1) * 32);
    lo[1] = (q2.size() != 0) && (q2.size() * 100 >= clamp100(bus_if.watermark_l2) * 128);
    lo[2] = (q3.size() != 0) && (q3.size() * 100 >= clamp100(bus_if.watermark_l3) * 512);
    return lo;
  endfunction

  function automatic bit m_bp();
    logic [2:0] lo = m_overflow();
    return lo[m_maxl()] | m_full();
  endfunction

  function automatic logic [31:0] m_status();
    return {bus_if.fifo_mode, m_full(), (q1.size() == 0), m_bp(), m_overflow(),
            10'(q3.size()), 8'(q2.size()), 6'(q1.size())};
  endfunction

  // One clock of the FIFO rules, evaluated on pre-edge occupancy.
  function automatic void model_step();
    int n1 = q1.size();
    int n2 = q2.size();
    int n3 = q3.size();
    int t  = m_target();
    bit acc = bus_if.wr_en && !m_full();
    int pop = (bus_if.rd_en && n1 > 0) ? 1 : 0;
    int r21 = (n2 > 0 && (n1 - pop) < 32) ? 1 : 0;
    int r32 = (n3 > 0 && (n2 - r21) < 128) ? 1 : 0;
    if (pop == 1) void'(q1.pop_front());
    if (r21 == 1) q1.push_back(q2.pop_front());
    if (r32 == 1) q2.push_back(q3.pop_front());
    if (acc) begin
      case (t)
        0:       q1.push_back(bus_if.wr_data);
        1:       q2.push_back(bus_if.wr_data);
        default: q3.push_back(bus_if.wr_data);
      endcase
    end
  endfunction

  // Advance the model on every rising edge.
  always @(posedge clk) begin
    if (rst) begin
      q1.delete();
      q2.delete();
      q3.delete();
      model_live <= 1'b1;
    end else if (model_live) begin
      model_step();
    end
  end

  // Compare every DUT output with the model mid-cycle.
  always @(negedge clk) begin
    if (model_live) begin
      check("l1_count", 32'(dut.l1_count), 32'(q1.size()));
      check("l2_count", 32'(dut.l2_count), 32'(q2.size()));
      check("l3_count", 32'(dut.l3_count), 32'(q3.size()));
      check("rd_empty", 32'(bus_if.rd_empty), 32'(q1.size() == 0));
      check("rd_data", 32'(bus_if.rd_data), 32'((q1.size() > 0) ? q1[0] : 16'h0000));
      check("wr_full", 32'(bus_if.wr_full), 32'(m_full()));
      check("wr_level", 32'(bus_if.wr_level), 32'(m_target()));
      check("rd_level", 32'(bus_if.rd_level), 32'(m_rdlevel()));
      check("level_overflow", 32'(bus_if.level_overflow), 32'(m_overflow()));
      check("backpressure", 32'(bus_if.backpressure_active), 32'(m_bp()));
      check("fifo_status", bus_if.fifo_status, m_status());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      bus_if.wr_en   = 1'b1;
      bus_if.wr_data = 16'(base + i);
      tick();
    end
    bus_if.wr_en = 1'b0;
  endtask

  task automatic read_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      check("rd_seq", 32'(bus_if.rd_data), 32'(16'(base + i)));
      check("rd_not_empty", 32'(bus_if.rd_empty), 32'd0);
      bus_if.rd_en = 1'b1;
      tick();
    end
    bus_if.rd_en = 1'b0;
  endtask

  task automatic check_counts(input string nm, input int c1, input int c2, input int c3);
    check({nm, "_l1"}, 32'(dut.l1_count), 32'(c1));
    check({nm, "_l2"}, 32'(dut.l2_count), 32'(c2));
    check({nm, "_l3"}, 32'(dut.l3_count), 32'(c3));
  endtask

  initial begin
    int pw;
    int pr;
    rst                 = 1'b1;
    bus_if.fifo_mode    = 2'b10;
    bus_if.watermark_l1 = 8'd75;
    bus_if.watermark_l2 = 8'd80;
    bus_if.watermark_l3 = 8'd90;
    bus_if.wr_data      = 16'h0000;
    bus_if.wr_en        = 1'b0;
    bus_if.rd_en        = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b0;

    // Reset state
    check("rst_empty", 32'(bus_if.rd_empty), 32'd1);
    check("rst_full", 32'(bus_if.wr_full), 32'd0);
    check("rst_rd_data", 32'(bus_if.rd_data), 32'd0);
    check("rst_status", bus_if.fifo_status, 32'h9000_0000);

    // 20 words stay in L1
    write_n(20, 16'h0000);
    check_counts("w20", 20, 0, 0);
    read_n(20, 16'h0000);
    check("w20_empty", 32'(bus_if.rd_empty), 32'd1);
    check_counts("w20_drain", 0, 0, 0);

    // 50 words spill into L2
    write_n(50, 16'h0100);
    check_counts("w50", 32, 18, 0);
    check("w50_wr_level", 32'(bus_if.wr_level), 32'd1);
    check("w50_lo", 32'(bus_if.level_overflow), 32'b001);
    read_n(50, 16'h0100);
    check_counts("w50_drain", 0, 0, 0);

    // 200 words reach L3
    write_n(200, 16'h0200);
    check_counts("w200", 32, 128, 40);
    check("w200_rd_level", 32'(bus_if.rd_level), 32'd2);
    read_n(20, 16'h0200);
    read_n(180, 16'h0214);
    check_counts("w200_drain", 0, 0, 0);

    // Completely full in three-level mode
    write_n(672, 16'h0400);
    check_counts("w672", 32, 128, 512);
    check("w672_full", 32'(bus_if.wr_full), 32'd1);
    check("w672_lo", 32'(bus_if.level_overflow), 32'b111);
    check("w672_bp", 32'(bus_if.backpressure_active), 32'd1);
    write_n(1, 16'hFFFF);
    check_counts("w672_drop", 32, 128, 512);
    read_n(672, 16'h0400);
    check("w672_empty", 32'(bus_if.rd_empty), 32'd1);

    // L1-only mode
    bus_if.fifo_mode = 2'b00;
    write_n(32, 16'h0800);
    check("m00_full", 32'(bus_if.wr_full), 32'd1);
    write_n(1, 16'hEEEE);
    check_counts("m00", 32, 0, 0);
    read_n(32, 16'h0800);

    // L1+L2 mode
    bus_if.fifo_mode = 2'b01;
    write_n(159, 16'h0900);
    check("m01_not_full", 32'(bus_if.wr_full), 32'd0);
    write_n(1, 16'h0900 + 159);
    check("m01_full", 32'(bus_if.wr_full), 32'd1);
    write_n(1, 16'hDDDD);
    check_counts("m01", 32, 128, 0);
    read_n(160, 16'h0900);

    // Steady-state simultaneous read and write with L3 occupied
    bus_if.fifo_mode = 2'b10;
    write_n(300, 16'h0A00);
    check_counts("ss_fill", 32, 128, 140);
    for (int i = 0; i < 100; i++) begin
      check("ss_rd", 32'(bus_if.rd_data), 32'(16'(16'h0A00 + i)));
      check("ss_total", 32'(dut.l1_count) + 32'(dut.l2_count) + 32'(dut.l3_count), 32'd300);
      bus_if.rd_en   = 1'b1;
      bus_if.wr_en   = 1'b1;
      bus_if.wr_data = 16'(16'h0A00 + 300 + i);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_if.rd_en = 1'b0;
    bus_if.wr_en = 1'b0;
    check_counts("mid_rst", 0, 0, 0);
    check("mid_rst_empty", 32'(bus_if.rd_empty), 32'd1);

    // Randomised traffic with mode and watermark changes
    pw = 50;
    pr = 50;
    for (int c = 0; c < 6000; c++) begin
      if (c % 300 == 0) begin
        case ($urandom_range(0, 4))
          0:       begin pw = 90;  pr = 10; end
          1:       begin pw = 60;  pr = 60; end
          2:       begin pw = 10;  pr = 90; end
          3:       begin pw = 100; pr = 0;  end
          default: begin pw = 50;  pr = 50; end
        endcase
      end
      if (c % 450 == 0) begin
        bus_if.fifo_mode    = 2'($urandom_range(0, 3));
        bus_if.watermark_l1 = 8'($urandom_range(0, 255));
        bus_if.watermark_l2 = 8'($urandom_range(0, 255));
        bus_if.watermark_l3 = 8'($urandom_range(0, 255));
      end
      bus_if.wr_en   = ($urandom_range(0, 99) < pw);
      bus_if.rd_en   = ($urandom_range(0, 99) < pr);
      bus_if.wr_data = 16'($urandom);
      rst            = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst          = 1'b0;
    bus_if.wr_en = 1'b0;
    bus_if.rd_en = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hierarchical_fifo_system.md
# hierarchical_fifo_system

Three-level, order-preserving FIFO with a 16-bit data path. Capacity is a small L1 buffer (32) backed by a larger L2 (128) and L3 (512). Writes spill into deeper levels as shallower ones fill. Data is refilled upward one entry per level per cycle, and all reads come from the L1 head. The block sits between a bursty acquisition front end and a slower consumer, and exports per-level watermark and backpressure status.

## Interface
- DATA_WIDTH, 16, data word width
- L1_DEPTH, 32, L1 entries
- L2_DEPTH, 128, L2 entries
- L3_DEPTH, 512, L3 entries
- clk  in  1  clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- fifo_mode  in  2  levels enabled: 00 L1 only, 01 L1+L2, 10/11 L1+L2+L3
- watermark_l1/l2/l3  in  8 each  fill threshold for each level, in percent; values above 100 are treated as 100
- wr_data  in  DATA_WIDTH  write data
- wr_en  in  1  write request
- wr_full  out  1  no enabled capacity left
- rd_en  in  1  pop request
- rd_data  out  DATA_WIDTH  L1 head, first-word fall-through; 0 when rd_empty
- rd_empty  out  1  l1_count == 0
- wr_level  out  2  level the next write targets (0/1/2)
- rd_level  out  2  highest-index non-empty level; 0 when all levels are empty
- fifo_status  out  32  [5:0] l1_count, [13:6] l2_count, [23:14] l3_count, [26:24] level_overflow, [27] backpressure_active, [28] rd_empty, [29] wr_full, [31:30] fifo_mode
- level_overflow  out  3  bit i set when count_i != 0 and count_i*100 >= watermark_i*depth_i; combinational, not sticky
- backpressure_active  out  1  level_overflow[highest enabled level] OR wr_full
- Internal count signals named l1_count (6b), l2_count (8b) and l3_count (10b) are mandatory and probed by verification.

## Operation
- Each level is a circular buffer with head/tail pointers and a count. The head read is combinational.
- Occupancy order is fixed: L1 holds the oldest data, then L2, then L3 (newest).
- Write acceptance: a write is accepted iff wr_en && !wr_full.
- Write target:
  - L3 if L3 is non-empty or L2 is full.
  - Otherwise L2 if L2 is non-empty or L1 is full.
  - Otherwise L1.
  - A target in a level disabled by fifo_mode means wr_full.
- wr_full is set when every enabled level is full: 32 / 160 / 672 entries for the three modes.
- Read: accepted iff rd_en && !rd_empty. It pops the L1 head.
- Refill L2→L1: moves one entry per cycle when L2 is non-empty and (l1_count − pop) < L1_DEPTH.
- Refill L3→L2: moves one entry per cycle when L3 is non-empty and (l2_count − refill out of L2) < L2_DEPTH.
- All transfers, the write and the read may happen in the same cycle. Each level has independent push and pop.
- Invariant: L2 non-empty implies L1 non-empty, and L3 non-empty implies L2 non-empty. This lets rd_empty be derived from L1 alone.
- Ignored requests:
  - A write while full is dropped with no state change.
  - A read while empty is ignored.
  - A simultaneous read and write while full still drops the write, because wr_full is evaluated on the pre-edge state.
- Mode changes affect only write targeting and full evaluation. Data already resident in a now-disabled level still refills and drains normally.
- Arithmetic: watermark comparisons use at least 17-bit products, so there is no overflow.

## Timing
- Reset (synchronous, rst=1 at an edge):
  - All pointers and counts go to 0. Storage is not cleared.
  - Outputs after reset: rd_empty=1, wr_full=0, rd_data=0, wr_level=0, rd_level=0, level_overflow=0, backpressure_active=0.
  - fifo_status carries zero counts plus live fifo_mode.
  - Reset mid-operation discards all contents in that cycle.
- Write-to-read latency: an accepted write into an empty FIFO appears on rd_data, with rd_empty=0, immediately after that edge.
- Read handshake: rd_data is valid whenever rd_empty=0. Raising rd_en consumes the current head at the next edge, and the next word appears after that edge. Sustained rate is one word per cycle.
- Refill latency: 1 cycle per level hop, with at most one hop per level per cycle. Back-to-back reads never stall while any level holds data.
- Status outputs are combinational from counts and inputs, so they are valid in the same cycle as the state.

## Test plan
- Reset (rst=1 for 5 cycles), mode 10, watermarks 75/80/90; write 20 words 0x0000–0x0013 → L1=20, L2=0, L3=0; read 20 → 0x0000..0x0013 in order; then rd_empty=1 and all counts 0.
- Write 50 words from 0x0100, no reads → L1=32, L2=18, wr_level=1, level_overflow[0]=1; read 50 → 0x0100..0x0131 in order, never rd_empty mid-stream.
- Write 200 words from 0x0200 → L1=32, L2=128, L3=40, rd_level=2; the first 20 reads return 0x0200..0x0213; drain the rest → all counts 0.
- Write 672 words from 0x0400 → total 672, wr_full=1, level_overflow=3'b111, backpressure_active=1; an extra write is dropped; drain → 672 words 0x0400..0x069F in order.
- Mode 00: the 33rd write is dropped, wr_full=1 at 32 entries. Mode 01: wr_full at 160 entries.
- Simultaneous read and write at steady state with L3 non-empty → total count unchanged, order preserved; assert rst mid-burst → all counts 0 and rd_empty=1 after that edge.
